// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 output-stationary systolic multiply core.
//   DEF_WIDTH / DEF_FRAC : default operand width and fractional bits (Q8.8)
//   RUN_LEN              : operand beats per product (k0..k3)
//   K_W                  : width of the RUN beat counter
//   state_t              : sequencing FSM states
//   acc_width()          : accumulator width for a given operand width
package mm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;
  localparam int RUN_LEN   = 4;
  localparam int K_W       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full signed product plus one guard bit for the two-term dot product.
  function automatic int acc_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element of the systolic array.
//   clk, rst_n   : clock, synchronous active-high reset (rst_n = 1 resets)
//   en           : update the accumulator on this edge
//   load         : with en, load the product instead of adding it (k0 beat)
//   pass_clr     : zero the pass registers instead of capturing the inputs
//   a_in, b_in   : operands arriving from the left / from above
//   a_out, b_out : registered operands forwarded right / down
//   acc          : signed accumulator, 2*WIDTH+1 bits, no per-step rounding
module mac_pe
  import mm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       load,
  input  logic                       pass_clr,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  output logic [WIDTH-1:0]           a_out,
  output logic [WIDTH-1:0]           b_out,
  output logic [acc_width(WIDTH)-1:0] acc
);

  localparam int ACC_W = acc_width(WIDTH);

  logic signed [2*WIDTH-1:0] prod;
  logic        [ACC_W-1:0]   prod_ext;

  assign prod     = $signed(a_in) * $signed(b_in);
  assign prod_ext = {prod[2*WIDTH-1], prod};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      if (pass_clr) begin
        a_out <= '0;
        b_out <= '0;
      end else begin
        a_out <= a_in;
        b_out <= b_in;
      end
      if (en) begin
        acc <= load ? prod_ext : acc + prod_ext;
      end
    end
  end

endmodule

// File: rtl/systolic_mm2x2.sv
// Output-stationary 2x2 systolic multiply core: C = A x B over a 4-beat
// skewed operand window, results presented with a one-cycle out_valid pulse.
//   clk, rst_n         : clock, synchronous active-high reset (rst_n = 1 resets)
//   start              : first skewed operand beat (k0) is present on this edge
//   a_in0, a_in1       : A row streams (row 1 lags by one cycle)
//   b_in0, b_in1       : B column streams (column 1 lags by one cycle)
//   busy               : a product is in flight
//   out_valid          : one-cycle pulse when c00..c11 are final
//   c00, c01, c10, c11 : results, held until the next completed product
// Build option: define SYSTOLIC_SAT_EN to saturate each result to the signed
// WIDTH range; otherwise the low WIDTH bits of the shifted sum are kept.
//
// Operand handshake: there is no back-pressure. start is only accepted in
// IDLE; the upstream stage must then present beats k1..k3 on the following
// edges unconditionally, and out_valid has no ready to wait for.
module systolic_mm2x2
  import mm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in0,
  input  logic [WIDTH-1:0] a_in1,
  input  logic [WIDTH-1:0] b_in0,
  input  logic [WIDTH-1:0] b_in1,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] c00,
  output logic [WIDTH-1:0] c01,
  output logic [WIDTH-1:0] c10,
  output logic [WIDTH-1:0] c11
);

  localparam int ACC_W = acc_width(WIDTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t         state, state_nxt;
  logic [K_W-1:0] k, k_nxt;
  logic           accept;
  logic           pe_en;
  logic           pass_clr;

  // Sequencing FSM: next state and beat counter.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        k_nxt = '0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
          k_nxt     = K_W'(1);
        end
      end
      RUN: begin
        k_nxt = k + K_W'(1);
        if (k == K_W'(RUN_LEN - 1)) begin
          state_nxt = DONE;
          k_nxt     = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  // The start edge is beat k0: accumulators load rather than sum. Outside a
  // product the pass registers are zeroed so the next k0 sees clean edges.
  assign pe_en    = accept || (state == RUN);
  assign pass_clr = !pe_en;

  logic [WIDTH-1:0] a00_q, b00_q, b01_q, a10_q;
  logic [WIDTH-1:0] pe01_a_unused, pe10_b_unused, pe11_a_unused, pe11_b_unused;
  logic [ACC_W-1:0] acc_q [4];

  mac_pe #(.WIDTH(WIDTH)) u_pe00 (
    .clk(clk), .rst_n(rst_n), .en(pe_en), .load(accept), .pass_clr(pass_clr),
    .a_in(a_in0), .b_in(b_in0), .a_out(a00_q), .b_out(b00_q), .acc(acc_q[0])
  );

  mac_pe #(.WIDTH(WIDTH)) u_pe01 (
    .clk(clk), .rst_n(rst_n), .en(pe_en), .load(accept), .pass_clr(pass_clr),
    .a_in(a00_q), .b_in(b_in1), .a_out(pe01_a_unused), .b_out(b01_q), .acc(acc_q[1])
  );

  mac_pe #(.WIDTH(WIDTH)) u_pe10 (
    .clk(clk), .rst_n(rst_n), .en(pe_en), .load(accept), .pass_clr(pass_clr),
    .a_in(a_in1), .b_in(b00_q), .a_out(a10_q), .b_out(pe10_b_unused), .acc(acc_q[2])
  );

  mac_pe #(.WIDTH(WIDTH)) u_pe11 (
    .clk(clk), .rst_n(rst_n), .en(pe_en), .load(accept), .pass_clr(pass_clr),
    .a_in(a10_q), .b_in(b01_q), .a_out(pe11_a_unused), .b_out(pe11_b_unused), .acc(acc_q[3])
  );

  // Result formation: floor shift back to the operand format, then reduce.
  logic signed [ACC_W-1:0] sh    [4];
  logic        [WIDTH-1:0] c_red [4];

  for (genvar n = 0; n < 4; n++) begin : g_reduce
    always_comb begin
      sh[n] = $signed(acc_q[n]) >>> FRAC;
`ifdef SYSTOLIC_SAT_EN
      if (sh[n] > SAT_MAX)      c_red[n] = SAT_MAX[WIDTH-1:0];
      else if (sh[n] < SAT_MIN) c_red[n] = SAT_MIN[WIDTH-1:0];
      else                      c_red[n] = sh[n][WIDTH-1:0];
`else
      c_red[n] = sh[n][WIDTH-1:0];
`endif
    end
  end

`ifndef SYSTOLIC_SAT_EN
  // Wrap mode discards the bits above WIDTH by design.
  logic unused_sh_hi;
  assign unused_sh_hi = ^{sh[0][ACC_W-1:WIDTH], sh[1][ACC_W-1:WIDTH],
                          sh[2][ACC_W-1:WIDTH], sh[3][ACC_W-1:WIDTH]};
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      k         <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      c00       <= '0;
      c01       <= '0;
      c10       <= '0;
      c11       <= '0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      busy      <= (state_nxt != IDLE);
      out_valid <= (state == DONE);
      // Accumulators settle at the k3 edge; capture them on the DONE edge.
      if (state == DONE) begin
        c00 <= c_red[0];
        c01 <= c_red[1];
        c10 <= c_red[2];
        c11 <= c_red[3];
      end
    end
  end

endmodule
